// File: rtl/seven_seg_scan_ctrl_if.sv
// Host-side bundle for the seven-segment scan controller: load strobe with
// value/dp going in, segment/anode drive and status coming back.
interface seven_seg_scan_ctrl_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;
  logic        pending;

  modport master (
    output load, value, dp,
    input  seg, an, frame_tick, pending
  );

  modport slave (
    input  load, value, dp,
    output seg, an, frame_tick, pending
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode hex scan controller with frame-synchronous value commit.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 16
) (
  input logic                  clk,
  input logic                  rst,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  logic [DIV_W-1:0] div_reg, div_next;
  logic [1:0]       digit_reg, digit_next;
  logic [15:0]      disp_val_reg, disp_val_next;
  logic [15:0]      pend_val_reg, pend_val_next;
  logic [3:0]       disp_dp_reg, disp_dp_next;
  logic [3:0]       pend_dp_reg, pend_dp_next;
  logic             pending_reg, pending_next;
  logic [7:0]       seg_reg, seg_next;
  logic [3:0]       an_reg, an_next;
  logic             frame_tick_reg, frame_tick_next;

  phase_t     phase;
  logic       frame_end;
  logic [6:0] digit_seg [4];
  logic [3:0] digit_lit;

  function automatic logic [6:0] decode7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Per-digit segment pattern and whether the digit's anode is enabled in DRIVE.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [6:0] pattern;
      assign pattern = decode7(disp_val_reg[gi*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      logic significant;
      if (gi == 0) begin : g_lsd
        assign significant = 1'b1;
      end else begin : g_upper
        assign significant = |disp_val_reg[15:gi*4];
      end
      // A suppressed digit still lights when its decimal point is requested.
      assign digit_lit[gi] = significant | disp_dp_reg[gi];
      assign digit_seg[gi] = significant ? pattern : 7'h7F;
`else
      assign digit_lit[gi] = 1'b1;
      assign digit_seg[gi] = pattern;
`endif
    end
  endgenerate

  assign frame_end = (digit_reg == 2'd3) && (div_reg == DIV_LAST);
  assign phase     = (div_reg < BLANK_END) ? PH_BLANK : PH_DRIVE;

  always_comb begin
    div_next        = div_reg + DIV_W'(1);
    digit_next      = digit_reg;
    disp_val_next   = disp_val_reg;
    disp_dp_next    = disp_dp_reg;
    pend_val_next   = pend_val_reg;
    pend_dp_next    = pend_dp_reg;
    pending_next    = pending_reg;
    frame_tick_next = frame_end;
    seg_next        = 8'hFF;
    an_next         = 4'hF;

    if (div_reg == DIV_LAST) begin
      div_next   = '0;
      digit_next = digit_reg + 2'd1;
    end

    if (frame_end && pending_reg) begin
      disp_val_next = pend_val_reg;
      disp_dp_next  = pend_dp_reg;
      pending_next  = 1'b0;
    end

    // A load coinciding with a commit lands after the old contents were taken.
    if (bus.load) begin
      pend_val_next = bus.value;
      pend_dp_next  = bus.dp;
      pending_next  = 1'b1;
    end

    if (phase == PH_DRIVE && digit_lit[digit_reg]) begin
      an_next  = ~(4'b0001 << digit_reg);
      seg_next = {~disp_dp_reg[digit_reg], digit_seg[digit_reg]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg        <= '0;
      digit_reg      <= 2'd0;
      disp_val_reg   <= 16'h0000;
      disp_dp_reg    <= 4'h0;
      pend_val_reg   <= 16'h0000;
      pend_dp_reg    <= 4'h0;
      pending_reg    <= 1'b0;
      seg_reg        <= 8'hFF;
      an_reg         <= 4'hF;
      frame_tick_reg <= 1'b0;
    end else begin
      div_reg        <= div_next;
      digit_reg      <= digit_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      pend_val_reg   <= pend_val_next;
      pend_dp_reg    <= pend_dp_next;
      pending_reg    <= pending_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.an         = an_reg;
  assign bus.frame_tick = frame_tick_reg;
  assign bus.pending    = pending_reg;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboarded bench for seven_seg_scan_ctrl: expected per-cycle outputs are
// queued per frame when stimulus is planned and popped as the DUT produces them.
module tb_seven_seg_scan_ctrl;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 4 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seven_seg_scan_ctrl_if ssif();

  seven_seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ssif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cur_s = -1;
  logic [6:0] dec_tbl [16];

  task automatic tick;
    @(negedge clk);
    cur_s++;
  endtask

  // Expected outputs for one frame (sample index 0 = first sample after boundary).
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int plo, input int phi);
    for (int s = 0; s < FRAME; s++) begin
      exp_t       e;
      int         dg;
      int         dv;
      logic       lit;
      logic [3:0] nib;
      logic [6:0] pat;
      dg     = s / CLK_DIV;
      dv     = s % CLK_DIV;
      e.an   = 4'hF;
      e.seg  = 8'hFF;
      e.ft   = (s == FRAME - 1);
      e.pend = (s >= plo) && (s <= phi);
      if (dv >= BLANK) begin
        lit = 1'b1;
        nib = v[4*dg +: 4];
        pat = dec_tbl[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (dg != 0 && (v >> (4*dg)) == 16'h0000) begin
          lit = d[dg];
          pat = 7'h7F;
        end
`endif
        if (lit) begin
          e.an  = ~(4'b0001 << dg);
          e.seg = {~d[dg], pat};
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_load(input logic l, input logic [15:0] v, input logic [3:0] d);
    ssif.load  = l;
    ssif.value = v;
    ssif.dp    = d;
  endtask

  task automatic test_reset;
    drive_load(1'b0, 16'h0000, 4'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ssif.seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got=%h want=ff", ssif.seg); end
    n_cmp++; if (ssif.an !== 4'hF) begin n_bad++; $display("FAIL reset_an got=%b want=1111", ssif.an); end
    n_cmp++; if (ssif.frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_ft got=%b want=0", ssif.frame_tick); end
    n_cmp++; if (ssif.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pend got=%b want=0", ssif.pending); end
    rst   = 1'b0;
    cur_s = -1;
    $display("reset: outputs checked, released");
  endtask

  task automatic test_idle;
    push_frame(16'h0000, 4'h0, 1, 0);
    push_frame(16'h0000, 4'h0, 1, 0);
    for (int i = 0; i < 2*FRAME; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL idle s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
    end
    $display("idle: two frames of 0000 checked");
  endtask

  task automatic test_load;
    push_frame(16'h0000, 4'h0, 11, 30);
    push_frame(16'h1F3A, 4'b0100, 1, 0);
    for (int i = 0; i < 2*FRAME; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL load s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
      if (i == 10) drive_load(1'b1, 16'h1F3A, 4'b0100);
      else         drive_load(1'b0, 16'h0000, 4'h0);
    end
    $display("load: 1F3A dp=0100 committed at frame boundary");
  endtask

  task automatic test_back_to_back;
    push_frame(16'h1F3A, 4'b0100, 6, 31);
    push_frame(16'h1234, 4'h0, 0, 30);
    push_frame(16'h0005, 4'h0, 1, 0);
    for (int i = 0; i < 3*FRAME; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL b2b s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
      if (i == 5)       drive_load(1'b1, 16'h9999, 4'hF);
      else if (i == 6)  drive_load(1'b1, 16'h1234, 4'h0);
      else if (i == 30) drive_load(1'b1, 16'h0005, 4'h0);
      else              drive_load(1'b0, 16'h0000, 4'h0);
    end
    $display("back_to_back: last-wins and boundary-cycle load checked");
  endtask

  task automatic test_reset_mid;
    push_frame(16'h0005, 4'h0, 13, 31);
    for (int i = 0; i <= 18; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL rstmid_pre s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
      if (i == 12) drive_load(1'b1, 16'hABCD, 4'hF);
      else         drive_load(1'b0, 16'h0000, 4'h0);
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ssif.an !== 4'hF) begin n_bad++; $display("FAIL rstmid_an got=%b want=1111", ssif.an); end
    n_cmp++; if (ssif.seg !== 8'hFF) begin n_bad++; $display("FAIL rstmid_seg got=%h want=ff", ssif.seg); end
    n_cmp++; if (ssif.pending !== 1'b0) begin n_bad++; $display("FAIL rstmid_pend got=%b want=0", ssif.pending); end
    n_cmp++; if (ssif.frame_tick !== 1'b0) begin n_bad++; $display("FAIL rstmid_ft got=%b want=0", ssif.frame_tick); end
    rst   = 1'b0;
    cur_s = -1;
    push_frame(16'h0000, 4'h0, 1, 0);
    push_frame(16'h0000, 4'h0, 1, 0);
    for (int i = 0; i < 2*FRAME; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL rstmid_post s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
    end
    $display("reset_mid: pending ABCD discarded, display restarted at 0000");
  endtask

  task automatic test_leading_zero;
    logic [15:0] vals [3];
    logic [3:0]  dps  [3];
    vals = '{16'h0007, 16'h0000, 16'h0007};
    dps  = '{4'b0000, 4'b0000, 4'b1000};
    push_frame(16'h0000, 4'h0, 4, 30);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) push_frame(vals[k], dps[k], 4, 30);
      else       push_frame(vals[k], dps[k], 1, 0);
    end
    for (int i = 0; i < 4*FRAME; i++) begin
      exp_t e, g;
      tick();
      e = exp_q.pop_front();
      g = '{an: ssif.an, seg: ssif.seg, ft: ssif.frame_tick, pend: ssif.pending};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL lzero s=%0d got an=%b seg=%h ft=%b pend=%b want an=%b seg=%h ft=%b pend=%b",
                 cur_s, g.an, g.seg, g.ft, g.pend, e.an, e.seg, e.ft, e.pend);
      end
      if ((i % FRAME) == 3 && (i / FRAME) < 3) drive_load(1'b1, vals[i / FRAME], dps[i / FRAME]);
      else                                      drive_load(1'b0, 16'h0000, 4'h0);
    end
    $display("leading_zero: 0007, 0000, 0007 dp=1000 checked");
  endtask

  initial begin
    dec_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_idle();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
